// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: fetch-control bus between hazard/branch/I-mem sources and the PC sequencer
interface pc_seq_ctrl_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
);
  logic [PC_W-1:0]  pc_cur;
  logic             stall_req;
  logic             br_taken;
  logic [PC_W-1:0]  br_target;
  logic             halt_det;
  logic             imem_rdy;
  logic [PC_W-1:0]  pc_in;
  logic             pc_wr_en;
  logic             ifid_wr_en;
  logic             ifid_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output pc_cur, stall_req, br_taken, br_target, halt_det, imem_rdy,
    input  pc_in, pc_wr_en, ifid_wr_en, ifid_flush, halted, stall_cnt
  );
  modport slave (
    input  pc_cur, stall_req, br_taken, br_target, halt_det, imem_rdy,
    output pc_in, pc_wr_en, ifid_wr_en, ifid_flush, halted, stall_cnt
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer arbitrating fetch, redirect, stall, I-mem miss and halt
module pc_seq_ctrl #(
  parameter int PC_W      = 16,
  parameter int INC       = 2,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 8
) (
  input logic         clk,
  input logic         rst,
  pc_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, FLUSH, MISS, HALT} state_t;
  localparam state_t     BR_STATE = (FLUSH_CYC > 1) ? FLUSH : RUN;
  localparam logic [1:0] FL_LOAD  = 2'(FLUSH_CYC - 1);
  state_t           state, nxt_state;
  logic [1:0]       flush_cnt, nxt_flush;
  logic             pend_vld, nxt_pend_vld;
  logic [PC_W-1:0]  pend_tgt, nxt_pend_tgt;
  logic [PC_W-1:0]  seq_pc, br_pc, pc_in, redir_pc;
  logic             pc_wr, ifid_wr, flush, redir;
  logic [CNT_W-1:0] stall_cnt;
  assign seq_pc = bus.pc_cur + PC_W'(INC);
  assign br_pc  = {bus.br_target[PC_W-1:1], 1'b0};
  // next-state and output arbitration; a redirect (live branch or pending one after a miss) is applied after the case
  always_comb begin
    pc_in        = bus.pc_cur;
    pc_wr        = 1'b0;
    ifid_wr      = 1'b0;
    flush        = 1'b0;
    redir        = 1'b0;
    redir_pc     = br_pc;
    nxt_state    = state;
    nxt_flush    = flush_cnt;
    nxt_pend_vld = pend_vld;
    nxt_pend_tgt = pend_tgt;
    case (state)
      RUN, FLUSH: begin
        if (bus.br_taken) redir = 1'b1;
        else if (bus.halt_det) nxt_state = HALT;
        else if (!bus.imem_rdy) begin
          flush     = 1'b1;
          nxt_state = MISS;
        end else if (bus.stall_req) flush = (state == FLUSH);
        else if (state == FLUSH) begin
          pc_in     = seq_pc;
          pc_wr     = 1'b1;
          flush     = 1'b1;
          nxt_flush = flush_cnt - 2'd1;
          nxt_state = (flush_cnt == 2'd1) ? RUN : FLUSH;
        end else begin
          pc_in   = seq_pc;
          pc_wr   = 1'b1;
          ifid_wr = 1'b1;
        end
      end
      MISS: begin
        if (!bus.imem_rdy) begin
          flush        = 1'b1;
          nxt_pend_vld = pend_vld | bus.br_taken;
          nxt_pend_tgt = bus.br_taken ? br_pc : pend_tgt;
        end else if (bus.br_taken || pend_vld) begin
          redir        = 1'b1;
          redir_pc     = bus.br_taken ? br_pc : pend_tgt;
          nxt_pend_vld = 1'b0;
        end else begin
          pc_in     = seq_pc;
          pc_wr     = 1'b1;
          ifid_wr   = 1'b1;
          nxt_state = RUN;
        end
      end
      default: ;
    endcase
    if (redir) begin
      pc_in     = redir_pc;
      pc_wr     = 1'b1;
      ifid_wr   = 1'b0;
      flush     = 1'b1;
      nxt_state = BR_STATE;
      nxt_flush = FL_LOAD;
    end
  end
  // controller state, flush countdown and pending miss-time redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
      pend_vld  <= 1'b0;
      pend_tgt  <= '0;
    end else begin
      state     <= nxt_state;
      flush_cnt <= nxt_flush;
      pend_vld  <= nxt_pend_vld;
      pend_tgt  <= nxt_pend_tgt;
    end
  end
  // saturating count of non-halted cycles in which the PC did not advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (state != HALT && !pc_wr && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
  assign bus.pc_in      = rst ? '0 : pc_in;
  assign bus.pc_wr_en   = !rst && pc_wr;
  assign bus.ifid_wr_en = !rst && ifid_wr;
  assign bus.ifid_flush = !rst && flush;
  assign bus.halted     = !rst && state == HALT;
  assign bus.stall_cnt  = stall_cnt;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed scoreboard bench for the PC sequencer
module tb_pc_seq_ctrl;
  typedef struct packed {
    logic [15:0] pc;
    logic        wr;
    logic        ifwr;
    logic        fl;
    logic        halt;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc  = 16'h0000;
  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];
  string       tq[$];
  pc_seq_ctrl_if #(.PC_W(16), .CNT_W(8)) bus ();
  pc_seq_ctrl #(.PC_W(16), .INC(2), .FLUSH_CYC(2), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic st, input logic br, input logic [15:0] tgt, input logic hd, input logic rdy);
    bus.pc_cur    = pc;
    bus.stall_req = st;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.halt_det  = hd;
    bus.imem_rdy  = rdy;
  endtask
  task automatic check_out();
    exp_t  e;
    exp_t  o;
    string t;
    e = q.pop_front();
    t = tq.pop_front();
    o = '{bus.pc_in, bus.pc_wr_en, bus.ifid_wr_en, bus.ifid_flush, bus.halted};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed pc_in=%h wr=%b ifwr=%b fl=%b halt=%b expected pc_in=%h wr=%b ifwr=%b fl=%b halt=%b",
             t, o.pc, o.wr, o.ifwr, o.fl, o.halt, e.pc, e.wr, e.ifwr, e.fl, e.halt);
    end
  endtask
  task automatic expect_now(input string tag, input logic [15:0] epc, input logic ewr, input logic eifwr, input logic efl, input logic eh);
    q.push_back('{epc, ewr, eifwr, efl, eh});
    tq.push_back(tag);
    check_out();
  endtask
  task automatic step(input string tag, input logic st, input logic br, input logic [15:0] tgt, input logic hd, input logic rdy,
                      input logic [15:0] epc, input logic ewr, input logic eifwr, input logic efl, input logic eh);
    drive(st, br, tgt, hd, rdy);
    q.push_back('{epc, ewr, eifwr, efl, eh});
    tq.push_back(tag);
    @(negedge clk);
    check_out();
    if (ewr) pc = epc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string tag, input logic [7:0] exp_cnt);
    tests++;
    assert (bus.stall_cnt === exp_cnt) else begin
      fails++;
      $error("FAIL %s observed stall_cnt=%0d expected %0d", tag, bus.stall_cnt, exp_cnt);
    end
  endtask
  initial begin
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    #1;
    expect_now("reset_idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("reset_cnt", 8'd0);
    drive(1'b0, 1'b1, 16'h0041, 1'b0, 1'b1);
    #1;
    expect_now("reset_gates_branch", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("seq0", 0, 0, 16'h0, 0, 1, 16'h0002, 1, 1, 0, 0);
    step("seq1", 0, 0, 16'h0, 0, 1, 16'h0004, 1, 1, 0, 0);
    step("seq2", 0, 0, 16'h0, 0, 1, 16'h0006, 1, 1, 0, 0);
    step("seq3", 0, 0, 16'h0, 0, 1, 16'h0008, 1, 1, 0, 0);
    chk_cnt("cnt_after_seq", 8'd0);
    pc = 16'hFFFE;
    step("wrap", 0, 0, 16'h0, 0, 1, 16'h0000, 1, 1, 0, 0);
    step("br_redirect", 0, 1, 16'h0041, 0, 1, 16'h0040, 1, 0, 1, 0);
    step("br_flush2", 0, 0, 16'h0, 0, 1, 16'h0042, 1, 0, 1, 0);
    step("post_flush_run", 0, 0, 16'h0, 0, 1, 16'h0044, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 16'h0, 0, 1, 16'h0044, 0, 0, 0, 0);
    chk_cnt("cnt_after_stall", 8'd3);
    step("stall_vs_br", 1, 1, 16'h0100, 0, 1, 16'h0100, 1, 0, 1, 0);
    step("stall_vs_br_flush2", 0, 0, 16'h0, 0, 1, 16'h0102, 1, 0, 1, 0);
    step("miss_enter", 0, 0, 16'h0, 0, 0, 16'h0102, 0, 0, 1, 0);
    step("miss_br20", 0, 1, 16'h0020, 0, 0, 16'h0102, 0, 0, 1, 0);
    step("miss_hold", 1, 0, 16'h0, 0, 0, 16'h0102, 0, 0, 1, 0);
    step("miss_br31", 0, 1, 16'h0031, 0, 0, 16'h0102, 0, 0, 1, 0);
    step("miss_hold2", 0, 0, 16'h0, 0, 0, 16'h0102, 0, 0, 1, 0);
    step("miss_pend_redirect", 0, 0, 16'h0, 0, 1, 16'h0030, 1, 0, 1, 0);
    step("miss_pend_flush2", 0, 0, 16'h0, 0, 1, 16'h0032, 1, 0, 1, 0);
    chk_cnt("cnt_after_miss", 8'd8);
    step("miss_plain_enter", 0, 0, 16'h0, 0, 0, 16'h0032, 0, 0, 1, 0);
    step("miss_plain_exit", 0, 0, 16'h0, 0, 1, 16'h0034, 1, 1, 0, 0);
    step("br_vs_halt", 0, 1, 16'h0200, 1, 1, 16'h0200, 1, 0, 1, 0);
    step("br_vs_halt_flush2", 0, 0, 16'h0, 0, 1, 16'h0202, 1, 0, 1, 0);
    step("halt_det", 0, 0, 16'h0, 1, 1, 16'h0202, 0, 0, 0, 0);
    step("halted_br_ignored", 0, 1, 16'h0080, 0, 1, 16'h0202, 0, 0, 0, 1);
    step("halted_miss_ignored", 1, 0, 16'h0, 0, 0, 16'h0202, 0, 0, 0, 1);
    chk_cnt("cnt_halt_frozen", 8'd10);
    rst = 1'b1;
    #1;
    expect_now("async_rst_halt", 16'h0000, 0, 0, 0, 0);
    chk_cnt("async_rst_cnt", 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pc = 16'h0000;
    step("run_after_rst", 0, 0, 16'h0, 0, 1, 16'h0002, 1, 1, 0, 0);
    step("miss2_enter", 0, 0, 16'h0, 0, 0, 16'h0002, 0, 0, 1, 0);
    step("miss2_br50", 0, 1, 16'h0050, 0, 0, 16'h0002, 0, 0, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("pend_discarded", 0, 0, 16'h0, 0, 1, 16'h0004, 1, 1, 0, 0);
    chk_cnt("cnt_after_miss_rst", 8'd0);
    for (int i = 0; i < 254; i++) step("long_stall", 1, 0, 16'h0, 0, 1, 16'h0004, 0, 0, 0, 0);
    chk_cnt("cnt_254", 8'd254);
    for (int i = 0; i < 46; i++) step("long_stall", 1, 0, 16'h0, 0, 1, 16'h0004, 0, 0, 0, 0);
    chk_cnt("cnt_saturated", 8'd255);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
